ysyx_22040632_btb: RTL

Parametrised branch target buffer for the fetch stage. Replaces the fixed 8-entry, always-taken BTB inside the fetch unit with a configurable fully-associative table that has per-entry valid bits, 2-bit saturating direction counters, and invalid-first/round-robin replacement. Lookup is combinational on the current fetch PC. Updates arrive from execute one per cycle. A fence clears the whole table.

---
 rtl/ysyx_22040632_riscv_pkg.sv | 23 ++
 rtl/ysyx_22040632_sat_cnt.sv | 49 ++++
 rtl/ysyx_22040632_btb.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared core package: BTB entry layout and the allocation counter value.
package ysyx_22040632_riscv_pkg;

  localparam int unsigned BTB_XLEN      = 32;
  localparam int unsigned BTB_CNT_W     = 2;
  localparam int unsigned BTB_MAX_CNT_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [BTB_XLEN-1:0]  tag;
    logic [BTB_XLEN-1:0]  target;
    logic [BTB_CNT_W-1:0] cnt;
  } btb_entry_t;

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic logic [BTB_MAX_CNT_W-1:0] BTB_CNT_WEAK_T(input int unsigned cnt_w);
    logic [BTB_MAX_CNT_W-1:0] v;
    v = {BTB_MAX_CNT_W{1'b0}};
    v[cnt_w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ysyx_22040632_sat_cnt.sv
// Saturating up/down counter with synchronous clear and load.
module ysyx_22040632_sat_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rrst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;

  // Next count: clear beats load beats inc/dec; inc/dec stop at the rails.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (load) begin
      cnt_nxt_s = load_val;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (dec && (cnt_r != CNT_ZERO)) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ysyx_22040632_btb.sv
// Fully-associative BTB with 2-bit-style direction counters and
// invalid-first / round-robin replacement. Lookup is combinational.
module ysyx_22040632_btb
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                       clk,
  input  logic                       rrst_n,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            lookup_pc_i,
  output logic                       hit_o,
  output logic                       pred_taken_o,
  output logic [XLEN-1:0]            pred_target_o,
  input  logic                       upd_valid_i,
  input  logic [XLEN-1:0]            upd_pc_i,
  input  logic [XLEN-1:0]            upd_target_i,
  input  logic                       upd_taken_i,
  output logic [$clog2(ENTRIES):0]   occupancy_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned OCC_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_WEAK  = CNT_W'(BTB_CNT_WEAK_T(CNT_W));
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO  = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [XLEN-1:0]  XLEN_ZERO = {XLEN{1'b0}};

  logic [ENTRIES-1:0] valid_r;
  logic [XLEN-1:0]    tag_r    [ENTRIES];
  logic [XLEN-1:0]    target_r [ENTRIES];
  logic [CNT_W-1:0]   cnt_s    [ENTRIES];
  logic [IDX_W-1:0]   victim_ptr_r;
  logic [OCC_W-1:0]   occupancy_r;

  logic [ENTRIES-1:0] lk_match_s;
  logic [IDX_W-1:0]   lk_idx_s;
  logic               lk_hit_s;
  logic [ENTRIES-1:0] upd_match_s;
  logic [IDX_W-1:0]   upd_idx_s;
  logic               upd_hit_s;
  logic [IDX_W-1:0]   inv_idx_s;
  logic               any_inv_s;
  logic               alloc_s;
  logic [IDX_W-1:0]   alloc_idx_s;

  // Tag match for lookup and update, plus one-hot to index conversion.
  always_comb begin
    lk_idx_s  = IDX_ZERO;
    upd_idx_s = IDX_ZERO;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      lk_match_s[i]  = valid_r[i] && (tag_r[i] == lookup_pc_i);
      upd_match_s[i] = valid_r[i] && (tag_r[i] == upd_pc_i);
      lk_idx_s  = lk_idx_s  | (lk_match_s[i]  ? IDX_W'(i) : IDX_ZERO);
      upd_idx_s = upd_idx_s | (upd_match_s[i] ? IDX_W'(i) : IDX_ZERO);
    end
    lk_hit_s  = |lk_match_s;
    upd_hit_s = upd_valid_i && (|upd_match_s);
  end

  // Lowest-index invalid entry; scanning downward leaves the lowest one.
  always_comb begin
    inv_idx_s = IDX_ZERO;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      inv_idx_s = valid_r[i] ? inv_idx_s : IDX_W'(i);
    end
    any_inv_s = ~(&valid_r);
  end

  assign alloc_s     = upd_valid_i && upd_taken_i && !upd_hit_s && !flush_i;
  assign alloc_idx_s = any_inv_s ? inv_idx_s : victim_ptr_r;

  // Direction counters, one per entry.
  for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_cnt
    ysyx_22040632_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rrst_n   (rrst_n),
      .clr      (flush_i),
      .load     (alloc_s && (alloc_idx_s == IDX_W'(g))),
      .load_val (CNT_WEAK),
      .inc      (upd_hit_s && upd_match_s[g] && upd_taken_i && !flush_i),
      .dec      (upd_hit_s && upd_match_s[g] && !upd_taken_i && !flush_i),
      .cnt      (cnt_s[g])
    );
  end

  // Entry storage: flush drops valid bits, allocation fills, taken hit retargets.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      valid_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_r[i]    <= XLEN_ZERO;
        target_r[i] <= XLEN_ZERO;
      end
    end else if (flush_i) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (alloc_s) begin
      valid_r[alloc_idx_s]  <= 1'b1;
      tag_r[alloc_idx_s]    <= upd_pc_i;
      target_r[alloc_idx_s] <= upd_target_i;
    end else if (upd_hit_s && upd_taken_i) begin
      target_r[upd_idx_s] <= upd_target_i;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Victim pointer advances only when a valid entry is replaced.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      victim_ptr_r <= IDX_ZERO;
    end else if (flush_i) begin
      victim_ptr_r <= IDX_ZERO;
    end else if (alloc_s && !any_inv_s) begin
      victim_ptr_r <= victim_ptr_r + IDX_ONE;
    end else begin
      victim_ptr_r <= victim_ptr_r;
    end
  end

  // Occupancy grows only on allocation into an empty slot.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      occupancy_r <= OCC_ZERO;
    end else if (flush_i) begin
      occupancy_r <= OCC_ZERO;
    end else if (alloc_s && any_inv_s) begin
      occupancy_r <= occupancy_r + OCC_ONE;
    end else begin
      occupancy_r <= occupancy_r;
    end
  end

  assign hit_o         = lk_hit_s;
  assign pred_taken_o  = lk_hit_s && cnt_s[lk_idx_s][CNT_W-1];
  assign pred_target_o = lk_hit_s ? target_r[lk_idx_s] : XLEN_ZERO;
  assign occupancy_o   = occupancy_r;

endmodule
